// File: rtl/via_timer_bank.sv
// Bank of NCHAN down-counting interval timers with shared IFR/IER interrupt logic.
// Each channel counts slow_clock ticks or synchronised ev_in rising edges.
module via_timer_bank #(
  parameter int NCHAN = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  input  logic [4:0]       addr,
  input  logic             strobe,
  input  logic             we,
  input  logic             slow_clock,
  input  logic [NCHAN-1:0] ev_in,
  output logic [NCHAN-1:0] tmr_out,
  output logic             irq
);

  localparam logic [4:0] A_IFR = 5'd28;
  localparam logic [4:0] A_IER = 5'd29;

  logic [NCHAN-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [NCHAN-1:0][WIDTH-1:0] lat_q, lat_d;
  logic [NCHAN-1:0][3:0]       ctl_q, ctl_d;
  logic [NCHAN-1:0] arm_q, arm_d;
  logic [NCHAN-1:0] tmr_q, tmr_d;
  logic [NCHAN-1:0] ifr_q, ifr_d;
  logic [NCHAN-1:0] ier_q, ier_d;
  logic [NCHAN-1:0] s1_q, s2_q, s3_q;
  logic [NCHAN-1:0] ev_rise;
  logic             irq_q;
  logic             wr, rd;

  assign wr      = strobe & we;
  assign rd      = strobe & ~we;
  assign ev_rise = s2_q & ~s3_q;

  always_comb begin
    logic hit, tick;
    cnt_d = cnt_q;
    lat_d = lat_q;
    ctl_d = ctl_q;
    arm_d = arm_q;
    tmr_d = tmr_q;
    ifr_d = ifr_q;
    ier_d = ier_q;
    hit   = 1'b0;
    tick  = 1'b0;
    // Clears are applied first so a same-cycle underflow set wins.
    if (wr && addr == A_IFR)
      ifr_d = ifr_q & ~data_in[NCHAN-1:0];
    if (wr && addr == A_IER) begin
      if (data_in[WIDTH-1])
        ier_d = ier_q | data_in[NCHAN-1:0];
      else
        ier_d = ier_q & ~data_in[NCHAN-1:0];
    end
    for (int c = 0; c < NCHAN; c++) begin
      hit  = strobe && addr[4:2] == 3'(c);
      tick = ~ctl_q[c][1] &
             (ctl_q[c][3] ? ev_rise[c] : slow_clock);
      if (hit && !we && addr[1:0] == 2'd0)
        ifr_d[c] = 1'b0;
      if (hit && we && addr[1:0] == 2'd1)
        lat_d[c] = data_in;
      if (hit && we && addr[1:0] == 2'd2)
        ctl_d[c] = data_in[3:0];
      if (hit && we && addr[1:0] == 2'd0) begin
        cnt_d[c] = data_in;
        lat_d[c] = data_in;
        ifr_d[c] = 1'b0;
        tmr_d[c] = 1'b0;
        arm_d[c] = 1'b1;
      end else if (tick) begin
        if (cnt_q[c] == '0) begin
          if (ctl_q[c][0]) begin
            cnt_d[c] = lat_q[c];
            ifr_d[c] = 1'b1;
            if (ctl_q[c][2])
              tmr_d[c] = ~tmr_q[c];
          end else begin
            cnt_d[c] = '1;
            if (arm_q[c]) begin
              ifr_d[c] = 1'b1;
              arm_d[c] = 1'b0;
              if (ctl_q[c][2])
                tmr_d[c] = 1'b1;
            end
          end
        end else begin
          cnt_d[c] = cnt_q[c] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    data_out = '0;
    unique case (1'b1)
      addr == A_IFR: begin
        data_out[NCHAN-1:0] = ifr_q;
        data_out[WIDTH-1]   = irq_q;
      end
      addr == A_IER: begin
        data_out[NCHAN-1:0] = ier_q;
        data_out[WIDTH-1]   = 1'b1;
      end
      default: begin
        for (int c = 0; c < NCHAN; c++) begin
          if (addr[4:2] == 3'(c)) begin
            unique case (addr[1:0])
              2'd0:    data_out = cnt_q[c];
              2'd1:    data_out = lat_q[c];
              2'd2:    data_out = WIDTH'(ctl_q[c]);
              default: data_out = '0;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      lat_q <= '0;
      ctl_q <= '0;
      arm_q <= '0;
      tmr_q <= '0;
      ifr_q <= '0;
      ier_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      ctl_q <= ctl_d;
      arm_q <= arm_d;
      tmr_q <= tmr_d;
      ifr_q <= ifr_d;
      ier_q <= ier_d;
      s1_q  <= ev_in;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      irq_q <= |(ifr_q & ier_q);
    end
  end

  assign tmr_out = tmr_q;
  assign irq     = irq_q;

  logic unused_rd;
  assign unused_rd = rd;

endmodule

// File: tb/tb_via_timer_bank.sv
// Scoreboard bench for via_timer_bank: stimulus queues expectations,
// a negedge monitor pops and compares on every read or probe cycle.
module tb_via_timer_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic [4:0]  addr = '0;
  logic        strobe = 1'b0;
  logic        we = 1'b0;
  logic        slow_clock = 1'b0;
  logic [3:0]  ev_in = '0;
  logic [3:0]  tmr_out;
  logic        irq;
  logic        probe = 1'b0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  via_timer_bank #(.NCHAN(4), .WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .data_out(data_out),
    .addr(addr),
    .strobe(strobe),
    .we(we),
    .slow_clock(slow_clock),
    .ev_in(ev_in),
    .tmr_out(tmr_out),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && ((strobe && !we) || probe)) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample addr=%0d", addr);
      end else begin
        exp_t e;
        logic [31:0] act;
        e = sb.pop_front();
        checks++;
        case (e.kind)
          1:       act = 32'(irq);
          2:       act = 32'(tmr_out);
          default: act = 32'(data_out);
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s got=%h want=%h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    addr = a;
    data_in = d;
    we = 1'b1;
    strobe = 1'b1;
    cyc();
    strobe = 1'b0;
    we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] x,
                    input string n);
    sb.push_back('{n, 0, x});
    addr = a;
    we = 1'b0;
    strobe = 1'b1;
    cyc();
    strobe = 1'b0;
  endtask

  task automatic chk(input int k, input logic [31:0] x,
                     input string n);
    sb.push_back('{n, k, x});
    probe = 1'b1;
    cyc();
    probe = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      slow_clock = 1'b1;
      cyc();
      slow_clock = 1'b0;
      repeat (9) cyc();
    end
  endtask

  task automatic evpulse();
    ev_in[2] = 1'b1;
    cyc();
    cyc();
    ev_in[2] = 1'b0;
    slow_clock = 1'b1;
    cyc();
    slow_clock = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    rd(28, 32'h0000, "rst_ifr");
    rd(29, 32'h8000, "rst_ier");
    rd(0, 32'h0000, "rst_cnt");
    chk(1, 0, "rst_irq");
    chk(2, 0, "rst_tmr");
    rd(3, 32'h0000, "rsvd");
    rd(30, 32'h0000, "unmapped");
    wr(1, 16'h1234);
    rd(1, 32'h1234, "latch_rw");
    rd(0, 32'h0000, "latch_no_side");

    // one-shot on ch0
    wr(2, 16'h0004);
    wr(29, 16'h8001);
    wr(0, 16'h0150);
    ticks(336);
    chk(1, 0, "os_irq_pre");
    rd(0, 32'h0000, "os_cnt_zero");
    ticks(1);
    chk(1, 1, "os_irq");
    chk(2, 4'b0001, "os_tmr");
    rd(0, 32'hFFFF, "os_cnt_wrap");
    cyc();
    chk(1, 0, "os_irq_clr");
    ticks(350);
    chk(1, 0, "os_irq_quiet");
    rd(28, 32'h0000, "os_noflag");

    // free-running on ch1
    wr(6, 16'h0005);
    wr(29, 16'h8002);
    wr(4, 16'h0150);
    ticks(336);
    rd(28, 32'h0000, "fr_pre");
    ticks(1);
    rd(28, 32'h8002, "fr_flag1");
    chk(2, 4'b0011, "fr_tmr1");
    wr(28, 16'h0002);
    cyc();
    chk(1, 0, "fr_irq_clr");
    ticks(337);
    chk(2, 4'b0001, "fr_tmr2");
    rd(28, 32'h8002, "fr_flag2");
    ticks(337);
    chk(2, 4'b0011, "fr_tmr3");

    // event mode on ch2
    wr(6, 16'h0006);
    wr(28, 16'h0002);
    wr(10, 16'h0008);
    wr(8, 16'h0003);
    repeat (3) evpulse();
    rd(8, 32'h0000, "ev_cnt");
    ev_in[2] = 1'b1;
    cyc();
    cyc();
    rd(28, 32'h0000, "ev_pre");
    ev_in[2] = 1'b0;
    rd(28, 32'h0004, "ev_flag");

    // collisions on ch3
    wr(28, 16'h0004);
    addr = 12;
    data_in = 16'h0077;
    we = 1'b1;
    strobe = 1'b1;
    slow_clock = 1'b1;
    cyc();
    strobe = 1'b0;
    we = 1'b0;
    slow_clock = 1'b0;
    rd(12, 32'h0077, "col_wr_tick");
    wr(12, 16'h0000);
    addr = 28;
    data_in = 16'h0008;
    we = 1'b1;
    strobe = 1'b1;
    slow_clock = 1'b1;
    cyc();
    strobe = 1'b0;
    we = 1'b0;
    slow_clock = 1'b0;
    rd(28, 32'h0008, "col_set_clr");

    // multi-channel with IER masking
    wr(6, 16'h0000);
    wr(10, 16'h0000);
    wr(14, 16'h0000);
    wr(28, 16'h000F);
    wr(29, 16'h0003);
    wr(29, 16'h8009);
    rd(29, 32'h8009, "ier_set");
    wr(0, 16'h0005);
    wr(4, 16'h0005);
    wr(8, 16'h0005);
    wr(12, 16'h0005);
    ticks(6);
    rd(28, 32'h800F, "mc_ifr");
    chk(1, 1, "mc_irq");
    chk(2, 4'b0001, "mc_tmr");
    wr(28, 16'h0009);
    cyc();
    rd(28, 32'h0006, "mc_ifr_part");
    chk(1, 0, "mc_irq_masked");
    wr(29, 16'h0009);
    rd(29, 32'h8000, "ier_clr");

    // reset mid-count
    wr(29, 16'h8001);
    wr(0, 16'h0010);
    ticks(3);
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    chk(1, 0, "rm_irq");
    chk(2, 0, "rm_tmr");
    rd(0, 32'h0000, "rm_cnt");
    rd(1, 32'h0000, "rm_latch");
    rd(2, 32'h0000, "rm_ctrl");
    rd(29, 32'h8000, "rm_ier");
    ticks(20);
    rd(28, 32'h0000, "rm_noflag");
    chk(1, 0, "rm_irq_quiet");

    repeat (3) cyc();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/via_timer_bank.md
Name: via_timer_bank

Overview:
- Parametrised bank of NCHAN independent down-counting interval timers with a shared interrupt controller.
- Successor to the VIA T1/T2 timer logic for PET/peripheral designs; sits on the same strobe/we register bus and the same slow_clock tick.
- Adds per-channel mode selection, external event counting, configurable counter width, and a per-channel square-wave/one-shot output.

Parameters:
- NCHAN, 4: number of timer channels, 1..7.
- WIDTH, 16: counter, latch and data-bus width in bits, 8..32.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  write data.
- data_out  output  WIDTH  read data; combinational from addr; unmapped addresses read 0.
- addr  input  5  register address.
- strobe  input  1  one-clk bus access qualifier.
- we  input  1  1 = write, 0 = read (valid with strobe).
- slow_clock  input  1  one-clk tick enable, the timer count rate.
- ev_in  input  NCHAN  external event inputs, asynchronous.
- tmr_out  output  NCHAN  per-channel timer output.
- irq  output  1  interrupt request, active-high.

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-low. Asserting reset clears counters, latches, CTRL, IFR, IER, tmr_out (=0), irq (=0) and the ev_in synchronisers, including mid-count.
- Per-channel address map, c = channel, addr = 4c + r:
  - r=0 COUNT. Write loads latch and counter with data_in, clears IFR[c], clears tmr_out[c] and arms the channel. Read returns the live counter; a strobed read clears IFR[c].
  - r=1 LATCH. Read/write the latch only; no side effects.
  - r=2 CTRL. [1:0] mode: 00 one-shot, 01 free-running, 1x stopped (counter holds). [2] output enable. [3] event mode: decrement on a rising ev_in[c] instead of slow_clock.
  - r=3 reserved: reads 0, writes ignored.
- Global registers:
  - addr 28 IFR. Bit c = channel c flag; write 1 to clear. Read bit WIDTH-1 = irq.
  - addr 29 IER. On write, bit WIDTH-1 = 1 sets the bits given as 1 in [NCHAN-1:0]; bit WIDTH-1 = 0 clears them. Read returns mask with bit WIDTH-1 = 1.
  - Any other address is unmapped.
- Tick: slow_clock=1 on a clk edge, or, in event mode, a rising edge of ev_in after a 2-FF synchroniser plus edge detect. Event latency is 3 clk from the ev_in rise.
- Counting: each tick decrements modulo 2^WIDTH. On a tick while counter==0 ("underflow"):
  - One-shot: if armed, set IFR[c], set tmr_out[c] (when output enabled), disarm. Counter wraps to all-ones and keeps counting; no further flags until COUNT is rewritten.
  - Free-running: reload counter from latch, set IFR[c], toggle tmr_out[c] (when output enabled).
- Period: a load of N produces the flag on the (N+1)th tick after the write. Free-running period is latch+1 ticks.
- Register-update latency: IFR updates on the underflow clk edge; irq = |(IFR & IER) is registered, so it rises 1 clk later.
- Simultaneous events:
  - COUNT write and tick on the same channel: the write wins; no decrement that cycle.
  - Flag set and clear (IFR write or COUNT read) in the same cycle: set wins.
  - LATCH write coincident with a free-running reload: the reload uses the old latch value.
  - Mode change mid-count: the counter value is preserved.
- Stopped mode: no ticks, no flags; tmr_out holds its value.

Test Plan:
- One-shot: slow_clock every 10 clk; IER←0x8001; write ch0 COUNT=0x0150 -> irq=0 after 336 ticks, irq=1 by 3 clk after tick 337, tmr_out[0]=1; read COUNT -> irq=0; wait 350 more ticks -> irq stays 0.
- Free-running: ch1 CTRL=0x05, COUNT=0x0150 -> IFR[1] set every 337 ticks, tmr_out[1] toggles 1,0,1; write IFR=0x0002 clears irq.
- Event mode: ch2 CTRL=0x08, COUNT=3; pulse ev_in[2] 4 times, ≥4 clk apart -> IFR[2]=1 exactly at the 4th pulse + 3 clk; slow_clock ignored.
- Collisions: COUNT write coincident with a slow_clock tick -> counter reads back the written value. Flag set coincident with an IFR clear write -> IFR bit stays 1.
- Multi-channel/IER: all 4 channels load 5, IER enables ch0 and ch3 only -> IFR=0x000F, irq=1; clear bits 0 and 3 -> irq=0 though IFR=0x0006; IER write 0x0009 (bit15=0) disables ch0 and ch3.
- Reset mid-count (pulse reset low) -> all outputs 0, COUNT reads 0, no flag ever fires afterwards without a new load.
